mor1kx_tlb_reload_responder: RTL and testbench

Responder end of the MMU hardware TLB-reload port: services the `tlb_reload_req`/`ack`/`addr`/`data` handshake issued by the data MMU and instruction MMU page-table walkers. It arbitrates between the two walkers and turns each request into a single Wishbone-classic 32-bit read. The read data, or zero on error, is returned with a one-cycle ack. It sits between both MMUs and the data-side bus arbiter.

---
 rtl/mor1kx_tlb_reload_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_mor1kx_tlb_reload_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_tlb_reload_responder.sv
// ---------------------------------------------------------------------------
// mor1kx_tlb_reload_responder
//
// Responder side of the MMU hardware TLB-reload port. The DMMU and IMMU page
// table walkers each raise a level request with a PTE address. This block
// arbitrates between them round-robin and issues one Wishbone-classic 32-bit
// read per request. It returns the read data, or zero on a bus error or
// timeout, together with a one-cycle ack to the owning walker.
//
// Once a walker is granted it keeps the grant across the dead GAP cycle. This
// keeps both reads of a two-level walk together, with no read from the other
// MMU in between.
//
// Optional feature macro: MOR1KX_TLB_RELOAD_TIMEOUT_EN
//   Defined   : a BUS-phase watchdog forces completion with zero data after
//               2^OPTION_TIMEOUT_WIDTH-1 cycles without a slave response.
//   Undefined : BUS waits indefinitely for wbm_ack_i / wbm_err_i.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous reset, active low
//   dmmu_req_i     DMMU reload request (level)
//   dmmu_addr_i    DMMU PTE address
//   dmmu_ack_o     one-cycle completion pulse to the DMMU
//   immu_req_i     IMMU reload request (level)
//   immu_addr_i    IMMU PTE address
//   immu_ack_o     one-cycle completion pulse to the IMMU
//   reload_data_o  read data, valid while either ack is high, held otherwise
//   wbm_adr_o      Wishbone address
//   wbm_cyc_o      Wishbone cycle
//   wbm_stb_o      Wishbone strobe (same timing as cyc)
//   wbm_we_o       Wishbone write enable, always 0
//   wbm_sel_o      Wishbone byte selects, always all ones
//   wbm_dat_i      Wishbone read data
//   wbm_ack_i      Wishbone ack
//   wbm_err_i      Wishbone error (wins over a simultaneous ack)
// ---------------------------------------------------------------------------
module mor1kx_tlb_reload_responder #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_TIMEOUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] reload_data_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [3:0]                      wbm_sel_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i
);

  localparam int OW = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic OWN_DMMU = 1'b0;
  localparam logic OWN_IMMU = 1'b1;

  state_t        state_r;
  state_t        state_s;
  logic          owner_r;
  logic          owner_s;
  logic          last_r;
  logic          last_s;
  logic [OW-1:0] adr_r;
  logic [OW-1:0] adr_s;
  logic [OW-1:0] data_r;
  logic [OW-1:0] data_s;
  logic          cyc_r;
  logic          cyc_s;
  logic          dack_r;
  logic          dack_s;
  logic          iack_r;
  logic          iack_s;
  logic          bus_start_s;
  logic          timeout_s;
  logic          owner_req_s;
  logic [OW-1:0] owner_addr_s;

  // A zero-width watchdog counter would be meaningless in either build.
  if (OPTION_TIMEOUT_WIDTH < 1) begin : g_bad_timeout_width
    $error("OPTION_TIMEOUT_WIDTH must be at least 1");
  end

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
  localparam int TW = OPTION_TIMEOUT_WIDTH;
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = {TW{1'b1}} - TMO_ONE;

  logic [TW-1:0] tmo_cnt_r;

  // Fires in the cycle whose increment would bring the count to all-ones,
  // so cyc is high for exactly 2^TW-1 unanswered cycles.
  assign timeout_s = (state_r == ST_BUS) && (tmo_cnt_r == TMO_LAST);

  // Watchdog counter: cleared on every entry to BUS, counts unanswered cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (bus_start_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_BUS) && !wbm_ack_i && !wbm_err_i) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  assign owner_req_s  = (owner_r == OWN_IMMU) ? immu_req_i  : dmmu_req_i;
  assign owner_addr_s = (owner_r == OWN_IMMU) ? immu_addr_i : dmmu_addr_i;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_s      = last_r;
    adr_s       = adr_r;
    data_s      = data_r;
    cyc_s       = cyc_r;
    dack_s      = 1'b0;
    iack_s      = 1'b0;
    bus_start_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // The DMMU wins unless the IMMU also requests and the DMMU was
        // the one granted last time.
        if (dmmu_req_i && (!immu_req_i || (last_r == OWN_IMMU))) begin
          owner_s     = OWN_DMMU;
          last_s      = OWN_DMMU;
          adr_s       = dmmu_addr_i;
          cyc_s       = 1'b1;
          bus_start_s = 1'b1;
          state_s     = ST_BUS;
        end else if (immu_req_i) begin
          owner_s     = OWN_IMMU;
          last_s      = OWN_IMMU;
          adr_s       = immu_addr_i;
          cyc_s       = 1'b1;
          bus_start_s = 1'b1;
          state_s     = ST_BUS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUS: begin
        if (wbm_err_i || wbm_ack_i || timeout_s) begin
          // Zero data decodes as PPN 0, so the walker sees a pagefault.
          if (wbm_err_i || !wbm_ack_i) begin
            data_s = {OW{1'b0}};
          end else begin
            data_s = wbm_dat_i;
          end
          cyc_s   = 1'b0;
          state_s = ST_RESP;
          // A walker that dropped its request mid-cycle gets no ack.
          if (owner_req_s) begin
            dack_s = (owner_r == OWN_DMMU);
            iack_s = (owner_r == OWN_IMMU);
          end else begin
            dack_s = 1'b0;
            iack_s = 1'b0;
          end
        end else begin
          state_s = ST_BUS;
        end
      end

      ST_RESP: begin
        // Without an ack the walker has abandoned the walk.
        if (dack_r || iack_r) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_GAP: begin
        // The walker has had one edge to present its next address.
        if (owner_req_s) begin
          adr_s       = owner_addr_s;
          cyc_s       = 1'b1;
          bus_start_s = 1'b1;
          state_s     = ST_BUS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      default: begin
        cyc_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered datapath, grant and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_r <= OWN_DMMU;
      last_r  <= OWN_IMMU;
      adr_r   <= {OW{1'b0}};
      data_r  <= {OW{1'b0}};
      cyc_r   <= 1'b0;
      dack_r  <= 1'b0;
      iack_r  <= 1'b0;
    end else begin
      owner_r <= owner_s;
      last_r  <= last_s;
      adr_r   <= adr_s;
      data_r  <= data_s;
      cyc_r   <= cyc_s;
      dack_r  <= dack_s;
      iack_r  <= iack_s;
    end
  end

  assign dmmu_ack_o    = dack_r;
  assign immu_ack_o    = iack_r;
  assign reload_data_o = data_r;
  assign wbm_adr_o     = adr_r;
  assign wbm_cyc_o     = cyc_r;
  assign wbm_stb_o     = cyc_r;
  assign wbm_we_o      = 1'b0;
  assign wbm_sel_o     = 4'hf;

endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// ---------------------------------------------------------------------------
// Testbench for mor1kx_tlb_reload_responder.
// Inputs are driven and outputs sampled on the falling clock edge. The bench
// acts as both walkers and as the Wishbone slave. A small reference model
// (round-robin winner, response data) supplies every expected value.
// ---------------------------------------------------------------------------
module tb_mor1kx_tlb_reload_responder;

  logic        clk;
  logic        rst;
  logic        dmmu_req;
  logic [31:0] dmmu_addr;
  logic        dmmu_ack;
  logic        immu_req;
  logic [31:0] immu_addr;
  logic        immu_ack;
  logic [31:0] reload_data;
  logic [31:0] wbm_adr;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat;
  logic        wbm_ack;
  logic        wbm_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: 1 = IMMU was granted last.
  bit          last_i;
  logic [31:0] last_data;

  mor1kx_tlb_reload_responder #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_TIMEOUT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dmmu_req_i   (dmmu_req),
    .dmmu_addr_i  (dmmu_addr),
    .dmmu_ack_o   (dmmu_ack),
    .immu_req_i   (immu_req),
    .immu_addr_i  (immu_addr),
    .immu_ack_o   (immu_ack),
    .reload_data_o(reload_data),
    .wbm_adr_o    (wbm_adr),
    .wbm_cyc_o    (wbm_cyc),
    .wbm_stb_o    (wbm_stb),
    .wbm_we_o     (wbm_we),
    .wbm_sel_o    (wbm_sel),
    .wbm_dat_i    (wbm_dat),
    .wbm_ack_i    (wbm_ack),
    .wbm_err_i    (wbm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner when requests are presented to an idle responder: 1 = IMMU.
  function automatic bit pick(input bit d, input bit i, input bit last_was_i);
    if (d && i) return !last_was_i;
    return i;
  endfunction

  // Wait (bounded) for cyc; n = number of falling edges it took.
  task automatic wait_cyc(input string tag, output int n);
    n = 0;
    while (!wbm_cyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cyc_rise"}, {31'd0, wbm_cyc}, 32'd1);
  endtask

  // Act as the slave for one read that is already on the bus.
  task automatic serve(input string tag, input logic [31:0] exp_adr, input int waits,
                       input logic [31:0] dat, input bit err, input bit ack_too,
                       input bit abort, input bit exp_d, input bit exp_i);
    check({tag, "_adr"}, wbm_adr, exp_adr);
    check({tag, "_stb"}, {31'd0, wbm_stb}, 32'd1);
    for (int w = 0; w < waits; w++) begin
      if (abort && w == 0) begin
        dmmu_req = 1'b0;
        immu_req = 1'b0;
      end
      @(negedge clk);
      check({tag, "_wait"}, {30'd0, wbm_cyc, dmmu_ack | immu_ack}, 32'd2);
    end
    wbm_dat = dat;
    wbm_ack = !err || ack_too;
    wbm_err = err;
    @(negedge clk);
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    wbm_dat = $urandom;
    last_data = err ? 32'd0 : dat;
    check({tag, "_cyc_drop"}, {31'd0, wbm_cyc}, 32'd0);
    check({tag, "_dack"}, {31'd0, dmmu_ack}, {31'd0, exp_d});
    check({tag, "_iack"}, {31'd0, immu_ack}, {31'd0, exp_i});
    check({tag, "_data"}, reload_data, last_data);
  endtask

  initial begin
    int n;
    int cnt;
    bit d;
    bit i;
    bit win;
    bit err;
    bit ack_too;
    bit abort;
    int waits;
    logic [31:0] da;
    logic [31:0] ia;
    logic [31:0] dat;
    logic [1:0] pat;

    rst = 1'b0;
    dmmu_req = 1'b0;
    immu_req = 1'b0;
    dmmu_addr = 32'd0;
    immu_addr = 32'd0;
    wbm_dat = 32'd0;
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    last_i = 1'b1;
    last_data = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
    check("rst_stb", {31'd0, wbm_stb}, 32'd0);
    check("rst_acks", {30'd0, dmmu_ack, immu_ack}, 32'd0);
    check("rst_adr", wbm_adr, 32'd0);
    check("rst_data", reload_data, 32'd0);
    check("rst_we_sel", {27'd0, wbm_we, wbm_sel}, 32'h0000_000f);
    rst = 1'b1;
    @(negedge clk);

    // Single DMMU read with two wait states.
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_1004;
    last_i = 1'b0;
    wait_cyc("single", n);
    check("single_latency", n, 32'd1);
    serve("single", 32'h0000_1004, 2, 32'h1234_6000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmmu_req = 1'b0;
    repeat (3) @(negedge clk);

    // Two-step walk; the IMMU request arrives mid-walk and has to wait.
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_2000;
    last_i = 1'b0;
    wait_cyc("walk1", n);
    immu_req = 1'b1;
    immu_addr = 32'h0000_3000;
    serve("walk1", 32'h0000_2000, 1, 32'h0040_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmmu_addr = 32'h0040_0808;
    @(negedge clk);
    check("walk_gap_cyc", {31'd0, wbm_cyc}, 32'd0);
    @(negedge clk);
    check("walk2_cyc", {31'd0, wbm_cyc}, 32'd1);
    serve("walk2", 32'h0040_0808, 0, 32'h0bad_c0de, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmmu_req = 1'b0;
    wait_cyc("walk_immu", n);
    check("walk_immu_latency", n, 32'd3);
    last_i = 1'b1;
    serve("walk_immu", 32'h0000_3000, 0, 32'h7777_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    immu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_data", reload_data, last_data);

    // Reset in the middle of a bus cycle.
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_4000;
    wait_cyc("rstbus", n);
    rst = 1'b0;
    @(negedge clk);
    check("rstbus_cyc", {31'd0, wbm_cyc}, 32'd0);
    check("rstbus_adr", wbm_adr, 32'd0);
    dmmu_req = 1'b0;
    last_i = 1'b1;
    last_data = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight after reset, twice.
    for (int rep = 0; rep < 2; rep++) begin
      dmmu_req = 1'b1;
      immu_req = 1'b1;
      dmmu_addr = 32'h0001_0000 + 32'(rep);
      immu_addr = 32'h0002_0000 + 32'(rep);
      win = pick(1'b1, 1'b1, last_i);
      last_i = win;
      wait_cyc("tie_first", n);
      serve("tie_first", win ? immu_addr : dmmu_addr, 1, $urandom, 1'b0, 1'b0, 1'b0, !win, win);
      if (win) immu_req = 1'b0;
      else dmmu_req = 1'b0;
      win = !win;
      last_i = win;
      wait_cyc("tie_second", n);
      check("tie_second_latency", n, 32'd3);
      serve("tie_second", win ? immu_addr : dmmu_addr, 0, $urandom, 1'b0, 1'b0, 1'b0, !win, win);
      dmmu_req = 1'b0;
      immu_req = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Bus error, then error together with ack, then a normal read.
    immu_req = 1'b1;
    immu_addr = 32'h0000_6000;
    last_i = 1'b1;
    wait_cyc("err", n);
    serve("err", 32'h0000_6000, 1, 32'hffff_ffff, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    immu_req = 1'b0;
    repeat (3) @(negedge clk);
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_6100;
    last_i = 1'b0;
    wait_cyc("errack", n);
    serve("errack", 32'h0000_6100, 0, 32'h5555_5555, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    dmmu_req = 1'b0;
    repeat (3) @(negedge clk);
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_6200;
    wait_cyc("after_err", n);
    serve("after_err", 32'h0000_6200, 0, 32'h0000_a5a5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmmu_req = 1'b0;
    repeat (3) @(negedge clk);

    // Abort: the request drops during BUS, the read still finishes, no ack.
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_7000;
    wait_cyc("abort", n);
    serve("abort", 32'h0000_7000, 2, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_idle_cyc", {31'd0, wbm_cyc}, 32'd0);

    // Randomised transactions against the model.
    for (int t = 0; t < 40; t++) begin
      pat = 2'($urandom_range(1, 3));
      d = pat[0];
      i = pat[1];
      da = $urandom & 32'hffff_fffc;
      ia = $urandom & 32'hffff_fffc;
      dat = $urandom;
      waits = $urandom_range(0, 4);
      err = ($urandom_range(0, 7) == 0);
      ack_too = $urandom_range(0, 1) == 1;
      abort = (waits > 0) && ($urandom_range(0, 5) == 0);
      dmmu_req = d;
      immu_req = i;
      dmmu_addr = da;
      immu_addr = ia;
      win = pick(d, i, last_i);
      last_i = win;
      wait_cyc("rnd", n);
      check("rnd_latency", n, 32'd1);
      serve("rnd", win ? ia : da, waits, dat, err, ack_too, abort, !win && !abort, win && !abort);
      dmmu_req = 1'b0;
      immu_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rnd_idle_cyc", {31'd0, wbm_cyc}, 32'd0);
      check("rnd_hold_data", reload_data, last_data);
    end

    // Unresponsive slave.
    dmmu_req = 1'b1;
    dmmu_addr = 32'h0000_8000;
    wait_cyc("tmo", n);
    cnt = 1;
    while (wbm_cyc && cnt < 40) begin
      @(negedge clk);
      if (wbm_cyc) cnt++;
    end
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    check("tmo_len", cnt, 32'd15);
    check("tmo_dack", {31'd0, dmmu_ack}, 32'd1);
    check("tmo_data", reload_data, 32'd0);
`else
    check("notmo_len", cnt, 32'd40);
    check("notmo_cyc", {31'd0, wbm_cyc}, 32'd1);
    wbm_ack = 1'b1;
    wbm_dat = 32'hcafe_f00d;
    @(negedge clk);
    wbm_ack = 1'b0;
    check("notmo_dack", {31'd0, dmmu_ack}, 32'd1);
    check("notmo_data", reload_data, 32'hcafe_f00d);
`endif
    dmmu_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
